// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin arbiter and word mux for the shared internal bus
module bus_arbiter #(
    parameter int N_REQ    = 7,
    parameter int IDX_W    = 3,
    parameter int WIDTH    = 16,
    parameter int HOLD_MAX = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       lock,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    input  logic                   stat_clr,
    output logic [N_REQ-1:0]       grant,
    output logic                   grant_valid,
    output logic [IDX_W-1:0]       owner,
    output logic [WIDTH-1:0]       bus_out,
    output logic                   timeout,
    output logic [15:0]            contention_cnt
);

    localparam int HC_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(HOLD_MAX - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REQ - 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic               grant_valid_q, grant_valid_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [HC_W-1:0]    hold_cnt_q, hold_cnt_d;
    logic               timeout_q, timeout_d;
    logic [15:0]        cnt_q, cnt_d;

    logic               held;
    logic               arbitrate;
    logic [IDX_W-1:0]   nxt_ptr;
    logic [IDX_W-1:0]   pick_ptr;
    logic [IDX_W:0]     pick;

    // Returns {found, index}; scanning offsets high-to-low lets the smallest offset win.
    function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [IDX_W-1:0] ptr);
        logic [IDX_W:0]   res;
        logic [IDX_W-1:0] kk;
        int               k;
        res = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            k = int'(ptr) + i;
            if (k >= N_REQ) k = k - N_REQ;
            kk = IDX_W'(k);
            if (r[kk]) res = {1'b1, kk};
        end
        return res;
    endfunction

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_valid_d = grant_valid_q;
        owner_d       = owner_q;
        rr_ptr_d      = rr_ptr_q;
        hold_cnt_d    = hold_cnt_q;
        timeout_d     = 1'b0;
        cnt_d         = cnt_q;
        arbitrate     = 1'b0;

        held     = req[owner_q] & lock[owner_q];
        nxt_ptr  = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
        pick_ptr = (state_q == OWN) ? nxt_ptr : rr_ptr_q;
        pick     = rr_pick(req, pick_ptr);

        case (state_q)
            IDLE: arbitrate = 1'b1;
            OWN: begin
                if (held && (hold_cnt_q < HOLD_LAST)) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end else begin
                    timeout_d = held;
                    rr_ptr_d  = nxt_ptr;
                    arbitrate = 1'b1;
                end
            end
            default: arbitrate = 1'b1;
        endcase

        // Release and re-grant share one edge, so owners change without an idle bubble.
        if (arbitrate) begin
            hold_cnt_d = '0;
            grant_d    = '0;
            if (pick[IDX_W]) begin
                state_d                 = OWN;
                grant_d[pick[IDX_W-1:0]] = 1'b1;
                owner_d                 = pick[IDX_W-1:0];
                grant_valid_d           = 1'b1;
            end else begin
                state_d       = IDLE;
                owner_d       = '0;
                grant_valid_d = 1'b0;
            end
        end

        if (stat_clr) begin
            cnt_d = '0;
        end else if (($countones(req) > 1) && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            owner_q       <= '0;
            rr_ptr_q      <= '0;
            hold_cnt_q    <= '0;
            timeout_q     <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            owner_q       <= owner_d;
            rr_ptr_q      <= rr_ptr_d;
            hold_cnt_q    <= hold_cnt_d;
            timeout_q     <= timeout_d;
            cnt_q         <= cnt_d;
        end
    end

    assign grant          = grant_q;
    assign grant_valid    = grant_valid_q;
    assign owner          = owner_q;
    assign timeout        = timeout_q;
    assign contention_cnt = cnt_q;
    assign bus_out        = grant_valid_q ? req_data[owner_q*WIDTH +: WIDTH] : '0;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed vector bench for bus_arbiter
module tb_bus_arbiter;

    logic          clk = 1'b0;
    logic          reset;
    logic [6:0]    req;
    logic [6:0]    lock;
    logic [111:0]  req_data;
    logic          stat_clr;
    logic [6:0]    grant;
    logic          grant_valid;
    logic [2:0]    owner;
    logic [15:0]   bus_out;
    logic          timeout;
    logic [15:0]   contention_cnt;

    int checks = 0;
    int errors = 0;

    logic [15:0] words [7];

    typedef struct packed {
        logic [6:0]  req;
        logic [6:0]  lock;
        logic        clr;
        logic [2:0]  own;
        logic        gv;
        logic        to;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs [27];

    bus_arbiter #(.N_REQ(7), .IDX_W(3), .WIDTH(16), .HOLD_MAX(4)) dut (
        .clk(clk), .reset(reset), .req(req), .lock(lock), .req_data(req_data),
        .stat_clr(stat_clr), .grant(grant), .grant_valid(grant_valid), .owner(owner),
        .bus_out(bus_out), .timeout(timeout), .contention_cnt(contention_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [2:0] own, input logic gv,
                               input logic to, input logic [15:0] cnt);
        logic [6:0]  eg;
        logic [15:0] eb;
        eg = gv ? (7'd1 << own) : 7'd0;
        eb = gv ? words[own] : 16'd0;
        chk({tag, " grant"}, {25'd0, grant}, {25'd0, eg});
        chk({tag, " owner"}, {29'd0, owner}, {29'd0, (gv ? own : 3'd0)});
        chk({tag, " grant_valid"}, {31'd0, grant_valid}, {31'd0, gv});
        chk({tag, " bus_out"}, {16'd0, bus_out}, {16'd0, eb});
        chk({tag, " timeout"}, {31'd0, timeout}, {31'd0, to});
        chk({tag, " contention_cnt"}, {16'd0, contention_cnt}, {16'd0, cnt});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        words[0] = 16'hA0A0; words[1] = 16'hB1B1; words[2] = 16'h1234; words[3] = 16'hD3D3;
        words[4] = 16'hE4E4; words[5] = 16'hF5F5; words[6] = 16'h0606;
        for (int i = 0; i < 7; i++) req_data[i*16 +: 16] = words[i];

        // req, lock, stat_clr, expected owner, grant_valid, timeout, contention_cnt
        vecs[0]  = '{7'h7F, 7'h00, 1'b0, 3'd0, 1'b1, 1'b0, 16'd1};
        vecs[1]  = '{7'h7F, 7'h00, 1'b0, 3'd1, 1'b1, 1'b0, 16'd2};
        vecs[2]  = '{7'h7F, 7'h00, 1'b0, 3'd2, 1'b1, 1'b0, 16'd3};
        vecs[3]  = '{7'h7F, 7'h00, 1'b0, 3'd3, 1'b1, 1'b0, 16'd4};
        vecs[4]  = '{7'h7F, 7'h00, 1'b0, 3'd4, 1'b1, 1'b0, 16'd5};
        vecs[5]  = '{7'h7F, 7'h00, 1'b0, 3'd5, 1'b1, 1'b0, 16'd6};
        vecs[6]  = '{7'h7F, 7'h00, 1'b0, 3'd6, 1'b1, 1'b0, 16'd7};
        vecs[7]  = '{7'h7F, 7'h00, 1'b0, 3'd0, 1'b1, 1'b0, 16'd8};
        vecs[8]  = '{7'h00, 7'h00, 1'b0, 3'd0, 1'b0, 1'b0, 16'd8};
        vecs[9]  = '{7'h04, 7'h00, 1'b0, 3'd2, 1'b1, 1'b0, 16'd8};
        vecs[10] = '{7'h00, 7'h00, 1'b0, 3'd0, 1'b0, 1'b0, 16'd8};
        vecs[11] = '{7'h30, 7'h10, 1'b0, 3'd4, 1'b1, 1'b0, 16'd9};
        vecs[12] = '{7'h30, 7'h10, 1'b0, 3'd4, 1'b1, 1'b0, 16'd10};
        vecs[13] = '{7'h30, 7'h10, 1'b0, 3'd4, 1'b1, 1'b0, 16'd11};
        vecs[14] = '{7'h30, 7'h10, 1'b0, 3'd4, 1'b1, 1'b0, 16'd12};
        vecs[15] = '{7'h30, 7'h10, 1'b0, 3'd5, 1'b1, 1'b1, 16'd13};
        vecs[16] = '{7'h00, 7'h00, 1'b0, 3'd0, 1'b0, 1'b0, 16'd13};
        vecs[17] = '{7'h40, 7'h40, 1'b0, 3'd6, 1'b1, 1'b0, 16'd13};
        vecs[18] = '{7'h40, 7'h40, 1'b0, 3'd6, 1'b1, 1'b0, 16'd13};
        vecs[19] = '{7'h01, 7'h40, 1'b0, 3'd0, 1'b1, 1'b0, 16'd13};
        vecs[20] = '{7'h00, 7'h00, 1'b0, 3'd0, 1'b0, 1'b0, 16'd13};
        vecs[21] = '{7'h02, 7'h04, 1'b0, 3'd1, 1'b1, 1'b0, 16'd13};
        vecs[22] = '{7'h02, 7'h04, 1'b0, 3'd1, 1'b1, 1'b0, 16'd13};
        vecs[23] = '{7'h00, 7'h00, 1'b0, 3'd0, 1'b0, 1'b0, 16'd13};
        vecs[24] = '{7'h03, 7'h00, 1'b1, 3'd0, 1'b1, 1'b0, 16'd0};
        vecs[25] = '{7'h03, 7'h00, 1'b0, 3'd1, 1'b1, 1'b0, 16'd1};
        vecs[26] = '{7'h00, 7'h00, 1'b0, 3'd0, 1'b0, 1'b0, 16'd1};

        reset = 1'b0; req = '0; lock = '0; stat_clr = 1'b0;
        #2;
        check_state("reset", 3'd0, 1'b0, 1'b0, 16'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int v = 0; v < 27; v++) begin
            req = vecs[v].req; lock = vecs[v].lock; stat_clr = vecs[v].clr;
            step();
            check_state($sformatf("vec%0d", v), vecs[v].own, vecs[v].gv, vecs[v].to, vecs[v].cnt);
        end

        // Async reset while MDR holds a lock: outputs drop without a clock edge.
        req = 7'h08; lock = 7'h08; stat_clr = 1'b0;
        step();
        check_state("mdr_lock", 3'd3, 1'b1, 1'b0, 16'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_state("async_reset", 3'd0, 1'b0, 1'b0, 16'd0);
        #1;
        reset = 1'b1;
        req = 7'h7F; lock = 7'h00;
        step();
        check_state("restart_idx0", 3'd0, 1'b1, 1'b0, 16'd1);

        // Saturation of the contention counter, then clear under continued contention.
        repeat (65541) @(posedge clk);
        #1;
        chk("cnt_saturate", {16'd0, contention_cnt}, 32'h0000FFFF);
        stat_clr = 1'b1;
        step();
        chk("cnt_clear", {16'd0, contention_cnt}, 32'd0);
        stat_clr = 1'b0;
        step();
        chk("cnt_after_clear", {16'd0, contention_cnt}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
